// File: rtl/vend_mealy_change_if.sv
// rtl/vend_mealy_change_if.sv - coin/cancel inputs and vending/refund outputs of vend_mealy_change
interface vend_mealy_change_if #(
  parameter int CW    = 3,
  parameter int CNT_W = 8
);
  logic [1:0]       D_in;
  logic             Cancel;
  logic             D_out_mealy;
  logic             D_out_reg;
  logic             Change_out;
  logic             Busy;
  logic [CW-1:0]    Credit;
  logic [CNT_W-1:0] Sold_cnt;

  modport master (
    output D_in, Cancel,
    input  D_out_mealy, D_out_reg, Change_out, Busy, Credit, Sold_cnt
  );

  modport slave (
    input  D_in, Cancel,
    output D_out_mealy, D_out_reg, Change_out, Busy, Credit, Sold_cnt
  );
endinterface

// File: rtl/vend_mealy_change.sv
// rtl/vend_mealy_change.sv - Mealy vending FSM with unit-by-unit change refund and sales counter
module vend_mealy_change #(
  parameter int PRICE     = 4,
  parameter int COIN0_VAL = 1,
  parameter int COIN1_VAL = 2,
  parameter int CNT_W     = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  vend_mealy_change_if.slave  bus
);

  localparam int CW = $clog2(PRICE + COIN0_VAL + COIN1_VAL + 1);
  localparam logic [CW-1:0] PRICE_W = CW'(PRICE);
  localparam logic [CW-1:0] COIN0_W = CW'(COIN0_VAL);
  localparam logic [CW-1:0] COIN1_W = CW'(COIN1_VAL);

  // One-hot-ish encoding leaves 00/11 as illegal codes that recover to IDLE.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b01,
    S_REFUND = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    credit_q, credit_d;
  logic [CW-1:0]    refund_q, refund_d;
  logic [CNT_W-1:0] sold_q, sold_d;
  logic             d_out_reg_q;

  logic [CW-1:0] coin_sum;
  logic [CW-1:0] total;
  logic          sale;

  assign coin_sum = (bus.D_in[0] ? COIN0_W : '0) + (bus.D_in[1] ? COIN1_W : '0);
  assign total    = credit_q + coin_sum;
  assign sale     = (state_q == S_IDLE) && !bus.Cancel && (coin_sum != '0) && (total >= PRICE_W);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      refund_q    <= '0;
      sold_q      <= '0;
      d_out_reg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      refund_q    <= refund_d;
      sold_q      <= sold_d;
      d_out_reg_q <= sale;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    refund_d = refund_q;
    sold_d   = sold_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Cancel) begin
          if (credit_q != '0) begin
            state_d  = S_REFUND;
            refund_d = credit_q;
            credit_d = '0;
          end
        end else if (sale) begin
          credit_d = '0;
          sold_d   = sold_q + CNT_W'(1);
          if (total != PRICE_W) begin
            state_d  = S_REFUND;
            refund_d = total - PRICE_W;
          end
        end else begin
          credit_d = total;
        end
      end
      S_REFUND: begin
        // Coins and Cancel are swallowed while change is paid out.
        credit_d = '0;
        refund_d = refund_q - CW'(1);
        if (refund_q <= CW'(1)) begin
          state_d  = S_IDLE;
          refund_d = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
        refund_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.D_out_mealy = sale & ~Reset;
    bus.D_out_reg   = d_out_reg_q;
    bus.Change_out  = (state_q == S_REFUND);
    bus.Busy        = (state_q == S_REFUND);
    bus.Credit      = credit_q;
    bus.Sold_cnt    = sold_q;
  end

endmodule
